// File: rtl/pram_dp.sv
// Dual-port RAM: port A read/write, port B read-only, with a power-up clear sweep
// that writes CLR_VAL to every word before raising ready.
module pram_dp #(
    parameter int unsigned    DW      = 8,
    parameter int unsigned    AW      = 8,
    parameter int unsigned    RD_LAT  = 1,
    parameter int unsigned    WMODE   = 0,
    parameter logic [DW-1:0]  CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] a_abus,
    input  logic [DW-1:0] a_dbus_i,
    input  logic          a_wr_en,
    output logic [DW-1:0] a_dbus_o,
    input  logic [AW-1:0] b_abus,
    output logic [DW-1:0] b_dbus_o,
    output logic          ready
);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] clr_cnt;
    logic [DW-1:0] mem [2**AW];

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            // wraps back to zero on the same edge that leaves CLEAR
            if (state == CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_addr   = a_abus;
        wr_data   = a_dbus_i;
        case (state)
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clr_cnt;
                wr_data = CLR_VAL;
                if (clr_cnt == '1)
                    state_nxt = READY;
            end
            READY: begin
                wr_en = a_wr_en;
            end
            default: state_nxt = CLEAR;
        endcase
    end

    assign ready = (state == READY);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    if (RD_LAT == 0) begin : g_async_rd
        // array content is undefined until the sweep completes, so mask it
        assign a_dbus_o = (state == CLEAR) ? CLR_VAL : mem[a_abus];
        assign b_dbus_o = (state == CLEAR) ? CLR_VAL : mem[b_abus];
    end else begin : g_sync_rd
        logic [DW-1:0] a_q, b_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q <= CLR_VAL;
                b_q <= CLR_VAL;
            end else if (state == CLEAR) begin
                a_q <= CLR_VAL;
                b_q <= CLR_VAL;
            end else begin
                a_q <= (WMODE != 0 && a_wr_en) ? a_dbus_i : mem[a_abus];
                b_q <= (WMODE != 0 && a_wr_en && b_abus == a_abus) ? a_dbus_i : mem[b_abus];
            end
        end

        assign a_dbus_o = a_q;
        assign b_dbus_o = b_q;
    end

endmodule
